stuff3_tx: RTL and testbench

- Serial transmitter with bit stuffing for a run-length-limited line, so that no more than MAX_RUN identical consecutive bits ever appear.
- Takes parallel words through a valid/ready handshake and shifts them out LSB first, one bit per clock.
- After every MAX_RUN identical consecutive line bits it inserts one complement bit.
- It feeds the seq3b-style run checker and the matching destuffing receiver: with MAX_RUN=2, a line from this block never shows three equal bits in a row.

---
 rtl/stuff3_tx_pkg.sv | 17 +
 rtl/stuff_run_tracker.sv | 39 +++
 rtl/stuff3_tx.sv | 97 +++++++++
 tb/tb_stuff3_tx.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stuff3_tx_pkg.sv
// rtl/stuff3_tx_pkg.sv - shared state encoding, defaults and widths for the bit-stuffing transmitter
package stuff3_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STUFF = 2'd2
    } tx_state_t;

    localparam int DEF_W       = 4;
    localparam int DEF_MAX_RUN = 2;

    function automatic int run_len_width(input int max_run);
        return $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/stuff_run_tracker.sv
// rtl/stuff_run_tracker.sv - run-length history of the line; flags when the current bit completes a run
module stuff_run_tracker
    import stuff3_tx_pkg::*;
#(
    parameter int MAX_RUN = DEF_MAX_RUN,
    parameter int RW      = run_len_width(MAX_RUN)
) (
    input  logic clk,
    input  logic rst,
    input  logic line_bit,
    input  logic bit_valid,
    output logic last_bit,
    output logic need_stuff
);

    logic [RW-1:0] run_len;
    logic [RW-1:0] next_run;

    // run_len==0 means no history yet, so the first bit always starts a fresh run
    always_comb begin
        next_run = RW'(1);
        if (line_bit == last_bit && run_len != '0) begin
            next_run = run_len + RW'(1);
        end
    end

    assign need_stuff = bit_valid && (next_run == RW'(MAX_RUN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_bit <= 1'b0;
            run_len  <= '0;
        end else if (bit_valid) begin
            last_bit <= line_bit;
            run_len  <= next_run;
        end
    end

endmodule

// File: rtl/stuff3_tx.sv
// rtl/stuff3_tx.sv - serial LSB-first transmitter inserting a complement bit after every MAX_RUN equal line bits
module stuff3_tx
    import stuff3_tx_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int MAX_RUN = DEF_MAX_RUN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         dout,
    output logic         dout_valid,
    output logic         dout_stuff
);

    localparam int CW = $clog2(W + 1);

    tx_state_t     state;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          line_bit;
    logic          last_bit;
    logic          need_stuff;
    logic          last_data;
    logic          accept;

    always_comb begin
        line_bit = 1'b0;
        case (state)
            ST_SHIFT: line_bit = shreg[0];
            ST_STUFF: line_bit = ~last_bit;
            default:  line_bit = 1'b0;
        endcase
    end

    assign dout       = line_bit;
    assign dout_valid = (state != ST_IDLE);
    assign dout_stuff = (state == ST_STUFF);

    assign last_data = (cnt == CW'(W - 1));
    assign din_ready = (state == ST_IDLE) ||
                       (state == ST_SHIFT && last_data && !need_stuff);
    assign accept    = din_valid && din_ready;

    stuff_run_tracker #(
        .MAX_RUN (MAX_RUN)
    ) u_run (
        .clk        (clk),
        .rst        (rst),
        .line_bit   (line_bit),
        .bit_valid  (dout_valid),
        .last_bit   (last_bit),
        .need_stuff (need_stuff)
    );

    // cnt runs on to W when the final data bit is followed by a stuff bit,
    // which is how STUFF knows the word is finished
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg <= din;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg >> 1;
                    cnt   <= cnt + CW'(1);
                    if (need_stuff) begin
                        state <= ST_STUFF;
                    end else if (last_data) begin
                        if (accept) begin
                            shreg <= din;
                            cnt   <= '0;
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_STUFF: begin
                    state <= (cnt == CW'(W)) ? ST_IDLE : ST_SHIFT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stuff3_tx.sv
// tb/tb_stuff3_tx.sv - directed self-checking bench for stuff3_tx (MAX_RUN=2 and MAX_RUN=3 instances)
module tb_stuff3_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'd0;
    logic       din_valid = 1'b0;
    logic       din_ready, dout, dout_valid, dout_stuff;
    logic [3:0] din_b = 4'd0;
    logic       din_valid_b = 1'b0;
    logic       din_ready_b, dout_b, dout_valid_b, dout_stuff_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic cap_bit[$];
    logic cap_stuff[$];
    logic cap_rdy[$];
    int   cap_cyc[$];

    int   run_a = 0, run_b = 0;
    logic last_a = 1'b0, last_b = 1'b0;

    stuff3_tx #(.W(4), .MAX_RUN(2)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_stuff(dout_stuff)
    );

    stuff3_tx #(.W(4), .MAX_RUN(3)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
        .dout(dout_b), .dout_valid(dout_valid_b), .dout_stuff(dout_stuff_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line checker on both lines: no run may exceed its MAX_RUN
    always @(negedge clk) begin
        if (rst) begin
            run_a = 0;
            run_b = 0;
        end else begin
            if (dout_valid) begin
                if (run_a > 0 && dout == last_a) run_a++; else run_a = 1;
                last_a = dout;
                checks++;
                if (run_a > 2) begin
                    errors++;
                    $display("FAIL run_limit_a cycle %0d run %0d allowed 2", cyc, run_a);
                end
            end
            if (dout_valid_b) begin
                if (run_b > 0 && dout_b == last_b) run_b++; else run_b = 1;
                last_b = dout_b;
                checks++;
                if (run_b > 3) begin
                    errors++;
                    $display("FAIL run_limit_b cycle %0d run %0d allowed 3", cyc, run_b);
                end
            end
        end
    end

    // '0'/'1' data bits, 'L'/'H' stuffed 0/1; returns {stuff, bit}
    function automatic logic [1:0] code(input byte c);
        case (c)
            "1":     return 2'b01;
            "L":     return 2'b10;
            "H":     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        din_valid_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] w);
        int b;
        din = w;
        din_valid = 1'b1;
        b = 0;
        #1;
        while (!din_ready && b < 60) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (!din_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout word %b din_ready %b wanted 1", w, din_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
    endtask

    task automatic capture(input int n, output int got);
        cap_bit.delete();
        cap_stuff.delete();
        cap_rdy.delete();
        cap_cyc.delete();
        got = 0;
        for (int c = 0; c < 80 && got < n; c++) begin
            @(negedge clk);
            if (dout_valid) begin
                cap_bit.push_back(dout);
                cap_stuff.push_back(dout_stuff);
                cap_rdy.push_back(din_ready);
                cap_cyc.push_back(cyc);
                got++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dout, dout_valid, dout_stuff} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000", {dout, dout_valid, dout_stuff});
        end
        checks++;
        if (dout_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_b got %b want 0", dout_valid_b);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", din_ready);
        end
    endtask

    task automatic test_zero_word();
        string s = "00H00H";
        int got;
        do_reset();
        fork
            push(4'b0000);
            capture(6, got);
        join
        checks++;
        if (got !== 6) begin errors++; $display("FAIL s1_count got %0d want 6", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if ({cap_stuff[i], cap_bit[i]} !== code(s[i])) begin
                errors++;
                $display("FAIL s1_line bit %0d got %b want %b", i, {cap_stuff[i], cap_bit[i]}, code(s[i]));
            end
        end
        @(negedge clk);
        checks++;
        if ({dout_valid, din_ready} !== 2'b01) begin
            errors++;
            $display("FAIL s1_idle got valid/ready %b want 01", {dout_valid, din_ready});
        end
    endtask

    task automatic test_back_to_back();
        string s = "10101010";
        int got;
        do_reset();
        fork
            begin push(4'b0101); push(4'b0101); end
            capture(8, got);
        join
        checks++;
        if (got !== 8) begin errors++; $display("FAIL s2_count got %0d want 8", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if ({cap_stuff[i], cap_bit[i]} !== code(s[i])) begin
                errors++;
                $display("FAIL s2_line bit %0d got %b want %b", i, {cap_stuff[i], cap_bit[i]}, code(s[i]));
            end
        end
        checks++;
        if (got == 8 && cap_cyc[7] - cap_cyc[0] !== 7) begin
            errors++;
            $display("FAIL s2_gap span %0d want 7", cap_cyc[7] - cap_cyc[0]);
        end
        checks++;
        if (got == 8 && {cap_rdy[0], cap_rdy[3]} !== 2'b01) begin
            errors++;
            $display("FAIL s2_ready cycles1/4 got %b want 01", {cap_rdy[0], cap_rdy[3]});
        end
    endtask

    task automatic test_history_boundary();
        string s = "100H011L0H0";
        int got;
        do_reset();
        fork
            begin push(4'b0001); push(4'b0011); end
            capture(11, got);
        join
        checks++;
        if (got !== 11) begin errors++; $display("FAIL s3_count got %0d want 11", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if ({cap_stuff[i], cap_bit[i]} !== code(s[i])) begin
                errors++;
                $display("FAIL s3_line bit %0d got %b want %b", i, {cap_stuff[i], cap_bit[i]}, code(s[i]));
            end
        end
        checks++;
        if (got == 11 && cap_cyc[10] - cap_cyc[0] !== 10) begin
            errors++;
            $display("FAIL s3_gap span %0d want 10", cap_cyc[10] - cap_cyc[0]);
        end
    endtask

    task automatic test_mid_reset();
        string s = "00H00H";
        int got;
        do_reset();
        fork
            push(4'b0000);
            capture(2, got);
        join
        rst = 1'b1;
        #1;
        checks++;
        if ({dout_valid, dout_stuff} !== 2'b00) begin
            errors++;
            $display("FAIL s4_async got %b want 00", {dout_valid, dout_stuff});
        end
        @(negedge clk);
        rst = 1'b0;
        fork
            push(4'b0000);
            capture(6, got);
        join
        checks++;
        if (got !== 6) begin errors++; $display("FAIL s4_count got %0d want 6", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if ({cap_stuff[i], cap_bit[i]} !== code(s[i])) begin
                errors++;
                $display("FAIL s4_line bit %0d got %b want %b", i, {cap_stuff[i], cap_bit[i]}, code(s[i]));
            end
        end
    endtask

    task automatic test_idle_gap();
        string s = "1L11L1";
        int got;
        do_reset();
        fork
            push(4'b0000);
            capture(6, got);
        join
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({dout_valid, dout} !== 2'b00) begin
                errors++;
                $display("FAIL s5_gap got valid/dout %b want 00", {dout_valid, dout});
            end
        end
        fork
            push(4'b1111);
            capture(6, got);
        join
        checks++;
        if (got !== 6) begin errors++; $display("FAIL s5_count got %0d want 6", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if ({cap_stuff[i], cap_bit[i]} !== code(s[i])) begin
                errors++;
                $display("FAIL s5_line bit %0d got %b want %b", i, {cap_stuff[i], cap_bit[i]}, code(s[i]));
            end
        end
    endtask

    task automatic test_max_run3();
        string s = "111L1";
        int got = 0;
        do_reset();
        din_b = 4'b1111;
        din_valid_b = 1'b1;
        checks++;
        if (din_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL s6_ready got %b want 1", din_ready_b);
        end
        @(posedge clk);
        #1;
        din_valid_b = 1'b0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (dout_valid_b) begin
                checks++;
                if ({dout_stuff_b, dout_b} !== code(s[got])) begin
                    errors++;
                    $display("FAIL s6_line bit %0d got %b want %b", got, {dout_stuff_b, dout_b}, code(s[got]));
                end
                got++;
            end
        end
        checks++;
        if (got !== 5) begin errors++; $display("FAIL s6_count got %0d want 5", got); end
        @(negedge clk);
        checks++;
        if (dout_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL s6_idle got %b want 0", dout_valid_b);
        end
    endtask

    initial begin
        test_reset();
        test_zero_word();
        test_back_to_back();
        test_history_boundary();
        test_mid_reset();
        test_idle_gap();
        test_max_run3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
